// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: accepts one request in IDLE, then moves s one bit per clock.
// It reports completion with a single-cycle done pulse and holds s/cout until the next accept.
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [WIDTH-1:0] s_q;
  logic            cout_q, busy_q, done_q;
  logic [1:0]      op_q;
  logic [CW-1:0]   cnt_q;

  logic [CW-1:0]   n_load;
  logic            b_big;
  logic [WIDTH-1:0] step_s;
  logic            step_c;

  // WIDTH is a power of two, so any bit at or above SW means b >= WIDTH.
  assign b_big = |b[WIDTH-1:SW];

  always_comb begin
    n_load = {1'b0, b[SW-1:0]};
    if (op != OP_ROR && b_big) n_load = CW'(WIDTH);
  end

  always_comb begin
    step_s = s_q;
    step_c = s_q[0];
    case (op_q)
      OP_SRL: step_s = {1'b0, s_q[WIDTH-1:1]};
      OP_SLL: begin
        step_s = {s_q[WIDTH-2:0], 1'b0};
        step_c = s_q[WIDTH-1];
      end
      OP_SRA: step_s = {s_q[WIDTH-1], s_q[WIDTH-1:1]};
      OP_ROR: step_s = {s_q[0], s_q[WIDTH-1:1]};
      default: step_s = s_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_SRL;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            s_q    <= a;
            op_q   <= op;
            cout_q <= 1'b0;
            cnt_q  <= n_load;
            busy_q <= 1'b1;
            if (n_load == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          s_q    <= step_s;
          cout_q <= step_c;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // start seen here is dropped; the requester must wait for busy=0
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
